// File: rtl/adc_pkg.sv
// Shared ADC definitions: sample width common with the SPI master stage,
// default averaging depth and the decimator state encoding.
package adc_pkg;

  localparam int unsigned ADC_DATA_W     = 12;
  localparam int unsigned ADC_AVG_LOG2_N = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } avg_state_e;

endpackage

// File: rtl/adc_result_holder.sv
// Single-entry valid/ready output register. A load that arrives while the
// entry is full and not being consumed is dropped and reported on 'dropped'.
module adc_result_holder #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              dropped
);

  logic accept_load;

  // The entry frees up in the same cycle it is consumed, so a load
  // coinciding with a handshake replaces the result without a bubble.
  assign accept_load = load && (!valid || ready);
  assign dropped     = load && valid && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (accept_load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_avg_decimator.sv
// Boxcar decimator: averages non-overlapping windows of 2^LOG2_N ADC samples
// with round-half-up and hands each result to a valid/ready output register.
module adc_avg_decimator
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W = ADC_DATA_W,
  parameter int unsigned LOG2_N = ADC_AVG_LOG2_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              clear_overrun,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic              overrun,
  output logic [LOG2_N:0]   win_count
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned N     = 1 << LOG2_N;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);
  localparam logic [ACC_W:0]   ROUND = (ACC_W + 1)'((1 << LOG2_N) >> 1);

  avg_state_e        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              win_done;
  logic [ACC_W:0]    sum_rnd;
  logic [DATA_W-1:0] result;
  logic              dropped;

  assign accept   = (state == ST_ACCUM) && enable && sample_valid;
  assign win_done = accept && (count == LAST);

  // The final sample is folded in combinationally so the result loads on the
  // same edge that restarts the window.
  assign sum_rnd = {1'b0, acc} + (ACC_W + 1)'(sample_data) + ROUND;
  assign result  = DATA_W'(sum_rnd >> LOG2_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          acc   <= '0;
          count <= '0;
          if (enable) state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (!enable) begin
            state <= ST_IDLE;
            acc   <= '0;
            count <= '0;
          end else if (sample_valid) begin
            if (count == LAST) begin
              acc   <= '0;
              count <= '0;
            end else begin
              acc   <= acc + ACC_W'(sample_data);
              count <= count + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  adc_result_holder #(
    .DATA_W(DATA_W)
  ) u_holder (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (win_done),
    .load_data(result),
    .ready    (avg_ready),
    .data     (avg_data),
    .valid    (avg_valid),
    .dropped  (dropped)
  );

  // Setting takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (dropped) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign win_count = count;

endmodule

// File: tb/tb_adc_avg_decimator.sv
// Directed bench for adc_avg_decimator with a queue scoreboard of expected
// averages checked at each output handshake.
`timescale 1ns/100ps
module tb_adc_avg_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        clear_overrun;
  logic [11:0] avg_data;
  logic        avg_valid;
  logic        avg_ready;
  logic        overrun;
  logic [3:0]  win_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] win[8];

  always #5 clk = ~clk;

  adc_avg_decimator #(
    .DATA_W(12),
    .LOG2_N(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .clear_overrun(clear_overrun),
    .avg_data     (avg_data),
    .avg_valid    (avg_valid),
    .avg_ready    (avg_ready),
    .overrun      (overrun),
    .win_count    (win_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Scoreboard: every consumed result must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && avg_valid === 1'b1 && avg_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {20'd0, avg_data}, 32'hFFFF_FFFF);
      end else begin
        check("scoreboard", {20'd0, avg_data}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < 8; i++) win[i] = v;
  endtask

  // Sends win[0..7] on consecutive cycles; keep=1 queues the rounded average.
  task automatic run_window(input bit keep);
    logic [15:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum += {4'd0, win[i]};
      if (i == 7) begin
        check("win_count_pre_last", {28'd0, win_count}, 32'd7);
        if (keep) exp_q.push_back(12'((sum + 16'd4) >> 3));
      end
      send(win[i]);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    sample_data   = '0;
    sample_valid  = 1'b0;
    clear_overrun = 1'b0;
    avg_ready     = 1'b1;
    #22;
    check("rst_avg_data", {20'd0, avg_data}, 0);
    check("rst_avg_valid", {31'd0, avg_valid}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_win_count", {28'd0, win_count}, 0);
    rst_n = 1'b1;
    step();

    // Eight samples of 100, one-cycle latency
    enable = 1'b1;
    step();
    fill(12'd100);
    for (int i = 0; i < 7; i++) send(win[i]);
    check("valid_before_last", {31'd0, avg_valid}, 0);
    exp_q.push_back(12'd100);
    send(win[7]);
    check("valid_latency", {31'd0, avg_valid}, 1);
    check("avg_100", {20'd0, avg_data}, 100);
    check("overrun_clean", {31'd0, overrun}, 0);
    check("win_count_restart", {28'd0, win_count}, 0);
    step();
    check("valid_cleared", {31'd0, avg_valid}, 0);

    // Rounding: 0..7 -> 4; seven zeros then 3 -> 0
    for (int i = 0; i < 8; i++) win[i] = 12'(i);
    run_window(1'b1);
    check("avg_ramp", {20'd0, avg_data}, 4);
    step();
    fill(12'd0);
    win[7] = 12'd3;
    run_window(1'b1);
    check("avg_round_down", {20'd0, avg_data}, 0);
    step();

    // Full scale, no wrap
    fill(12'd4095);
    run_window(1'b1);
    check("avg_full_scale", {20'd0, avg_data}, 4095);
    step();

    // Sixteen back-to-back strobes -> two results, no gap
    fill(12'd200);
    run_window(1'b1);
    fill(12'd300);
    run_window(1'b1);
    check("avg_b2b_second", {20'd0, avg_data}, 300);
    step();

    // Backpressure: 50 kept, 60 dropped
    avg_ready = 1'b0;
    fill(12'd50);
    run_window(1'b1);
    fill(12'd60);
    run_window(1'b0);
    check("held_data", {20'd0, avg_data}, 50);
    check("held_valid", {31'd0, avg_valid}, 1);
    check("overrun_set", {31'd0, overrun}, 1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 0);
    avg_ready = 1'b1;
    step();
    check("valid_after_handshake", {31'd0, avg_valid}, 0);

    // Partial window discarded by enable=0; idle strobes ignored
    for (int i = 0; i < 5; i++) send(12'd900);
    check("partial_count", {28'd0, win_count}, 5);
    enable = 1'b0;
    step();
    send(12'd900);
    step();
    check("disabled_count", {28'd0, win_count}, 0);
    enable = 1'b1;
    step();
    fill(12'd10);
    run_window(1'b1);
    check("avg_after_disable", {20'd0, avg_data}, 10);
    step();

    // Asynchronous reset mid-window
    for (int i = 0; i < 4; i++) send(12'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", {28'd0, win_count}, 0);
    check("async_rst_data", {20'd0, avg_data}, 0);
    check("async_rst_valid", {31'd0, avg_valid}, 0);
    check("async_rst_overrun", {31'd0, overrun}, 0);
    #2;
    rst_n = 1'b1;
    step();
    fill(12'd7);
    run_window(1'b1);
    check("avg_after_reset", {20'd0, avg_data}, 7);

    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
